neat_struct_mutator: RTL

NEAT_STRUCT_MUTATOR -- requirements
Module: neat_struct_mutator

---
 rtl/neat_struct_mutator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/neat_struct_mutator.sv
// NEAT gene mutator: applies node / connection mutations to a gene stream and buffers 1-3 result genes per input.
// Latency: mutation decision is combinational at acceptance; the first result gene is visible at gene_out one cycle later.
// Backpressure: in_ready drops when fewer than 3 FIFO entries are free (or during setup); out_ready gates FIFO pops.
// Optional feature: define NEAT_CONN_MUT_EN to enable the pending new-connection mutation.
module neat_struct_mutator #(
    parameter int GENE_SZ = 64,
    parameter int ATTR_SZ = 8,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     setup,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [GENE_SZ-1:0]       gene_in,
    input  logic [ATTR_SZ-1:0]       random,
    input  logic [ATTR_SZ-1:0]       node_add_prob,
    input  logic [ATTR_SZ-1:0]       conn_add_prob,
    input  logic [ATTR_SZ-1:0]       genome_id,
    input  logic [ATTR_SZ-1:0]       global_hidden_node_max,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [GENE_SZ-1:0]       gene_out,
    output logic [ATTR_SZ-1:0]       hidden_node_max,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [ATTR_SZ-1:0] CONN_TYPE = {1'b1, {(ATTR_SZ-1){1'b0}}};
    localparam logic [ATTR_SZ-1:0] ONE       = ATTR_SZ'(1);
    localparam logic [ATTR_SZ-1:0] ZERO      = '0;
    localparam logic [ATTR_SZ-1:0] ALL_ONES  = '1;

    // Assemble a gene from its six meaningful fields; F1/F0 are always zero.
    function automatic logic [GENE_SZ-1:0] mk_gene(
        input logic [ATTR_SZ-1:0] f7, input logic [ATTR_SZ-1:0] f6,
        input logic [ATTR_SZ-1:0] f5, input logic [ATTR_SZ-1:0] f4,
        input logic [ATTR_SZ-1:0] f3, input logic [ATTR_SZ-1:0] f2);
        return {f7, f6, f5, f4, f3, f2, {(2*ATTR_SZ){1'b0}}};
    endfunction

    // Configuration captured at setup
    logic [ATTR_SZ-1:0] node_add_prob_reg;
    logic [ATTR_SZ-1:0] conn_add_prob_reg;

    // Output FIFO storage and bookkeeping
    logic [GENE_SZ-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    // Per-cycle decision
    logic               accept;
    logic               pop;
    logic               node_mut;
    logic [2:0]         push_en;
    logic [1:0]         push_cnt;
    logic [GENE_SZ-1:0] push_dat [3];
    logic [ATTR_SZ-1:0] new_node;
    logic [ATTR_SZ-1:0] f_src;
    logic [ATTR_SZ-1:0] f_dest;
    logic [ATTR_SZ-1:0] f_weight;

    assign f_src    = gene_in[5*ATTR_SZ +: ATTR_SZ];
    assign f_dest   = gene_in[4*ATTR_SZ +: ATTR_SZ];
    assign f_weight = gene_in[3*ATTR_SZ +: ATTR_SZ];
    assign new_node = hidden_node_max + ONE;

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign in_ready   = !setup && (count <= CW'(DEPTH - 3));
    assign accept     = in_valid && in_ready;
    assign gene_out   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = count;

    // A node id of all-ones cannot be incremented, so saturation skips node mutation entirely.
    assign node_mut = accept && mode && (random > node_add_prob_reg) && (hidden_node_max != ALL_ONES);

`ifdef NEAT_CONN_MUT_EN
    logic               pending;
    logic [ATTR_SZ-1:0] src_reg;
    logic               pending_set;
    logic               pending_clr;
`else
    // Without the connection feature there is never an open connection; conn_add_prob_reg is kept only as state.
    logic               pending;
    logic               conn_unused;
    assign pending     = 1'b0;
    assign conn_unused = ^{conn_add_prob_reg, pending};
`endif

    // Choose which genes (in emission order) enter the FIFO for an accepted input.
    always_comb begin
        push_en     = 3'b000;
        push_dat[0] = gene_in;
        push_dat[1] = '0;
        push_dat[2] = '0;
`ifdef NEAT_CONN_MUT_EN
        pending_set = 1'b0;
        pending_clr = 1'b0;
`endif
        if (accept) begin
            if (!mode) begin
                push_en = 3'b001;
            end else if (node_mut) begin
                // Split the connection: new hidden node, src->N with unit weight, N->dest keeping the old weight.
                push_en     = 3'b111;
                push_dat[0] = mk_gene(genome_id, ZERO, new_node, ZERO, ZERO, ONE);
                push_dat[1] = mk_gene(genome_id, CONN_TYPE, f_src, new_node, ONE, ONE);
                push_dat[2] = mk_gene(genome_id, CONN_TYPE, new_node, f_dest, f_weight, ONE);
`ifdef NEAT_CONN_MUT_EN
            end else if ((random > conn_add_prob_reg) && !pending) begin
                // Open a new connection from this gene's source; it closes on a later gene's destination.
                push_en     = 3'b001;
                pending_set = 1'b1;
            end else begin
                push_en = 3'b001;
                if (pending) begin
                    push_en     = 3'b011;
                    push_dat[1] = mk_gene(genome_id, CONN_TYPE, src_reg, f_dest, ONE, ONE);
                    pending_clr = 1'b1;
                end
`else
            end else begin
                push_en = 3'b001;
`endif
            end
        end
    end

    assign push_cnt = {1'b0, push_en[0]} + {1'b0, push_en[1]} + {1'b0, push_en[2]};

    // Configuration load at setup and hidden node counter advance on node mutation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_add_prob_reg <= '0;
            conn_add_prob_reg <= '0;
            hidden_node_max   <= '0;
        end else if (setup) begin
            node_add_prob_reg <= node_add_prob;
            conn_add_prob_reg <= conn_add_prob;
            hidden_node_max   <= global_hidden_node_max;
        end else if (node_mut) begin
            hidden_node_max   <= new_node;
        end
    end

`ifdef NEAT_CONN_MUT_EN
    // Open-connection tracking; a node mutation in between leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            src_reg <= '0;
        end else if (setup) begin
            pending <= 1'b0;
        end else if (pending_set) begin
            pending <= 1'b1;
            src_reg <= f_src;
        end else if (pending_clr) begin
            pending <= 1'b0;
        end
    end
`endif

    // FIFO pointers and occupancy; setup flushes so no partial mutation group survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (setup) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push_cnt) - CW'(pop);
        end
    end

    // Write up to three consecutive entries; pointer arithmetic wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push_en[i]) begin
                mem[wr_ptr + AW'(i)] <= push_dat[i];
            end
        end
    end

endmodule
